wb_trace_checker: RTL and testbench

WB_TRACE_CHECKER -- requirements
Module: wb_trace_checker

---
 rtl/wb_trace_pkg.sv | 18 +
 rtl/trace_fifo.sv | 56 +++++
 rtl/wb_trace_checker.sv | 121 ++++++++++++
 tb/tb_wb_trace_checker.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace checker.
// State encodings are visible on the state output, so the values are fixed.
package wb_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [4:0] REG_X0 = 5'd0;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Retire-trace FIFO: power-of-two depth, wrapping pointers, first-word fall-through.
// Storage is not reset; only pointers and occupancy are.
module trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ready,
  output logic                     valid,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             pop;
  logic             wr_en;

  assign valid = (count != '0);
  assign full  = (count == FULL_CNT);
  assign pop   = valid && ready;
  // A pop in the same cycle frees the slot, so a full push still lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_trace_checker.sv
// Run-phase monitor: traces retired writebacks, detects halt/timeout,
// then compares register check lanes once and holds the verdict.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | counting cycles, tracing retires, watching PC for halt
// CHECK | one cycle: capture lane mismatches
// DONE  | verdict held until reset
module wb_trace_checker
  import wb_trace_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH       = 16,
  parameter int NCHK        = 8,
  parameter int MAX_CYCLES  = 40,
  parameter int HALT_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     wb_en,
  input  logic [4:0]               wb_rd,
  input  logic [XLEN-1:0]          wb_data,
  input  logic [XLEN-1:0]          pc_if,
  input  logic [NCHK*XLEN-1:0]     chk_act,
  input  logic [NCHK*XLEN-1:0]     chk_exp,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [4:0]               trace_rd,
  output logic [XLEN-1:0]          trace_data,
  output logic [$clog2(DEPTH):0]   trace_count,
  output logic                     trace_overflow,
  output logic [31:0]              cycle_count,
  output logic [31:0]              retire_count,
  output logic [1:0]               state,
  output logic                     done,
  output logic                     pass,
  output logic [NCHK-1:0]          mismatch_mask
);

  localparam int          HW       = $clog2(HALT_CYCLES + 1) + 1;
  localparam logic [HW-1:0] HALT_LIM = HW'(HALT_CYCLES);
  localparam logic [31:0] CYC_LAST = 32'(MAX_CYCLES - 1);

  state_t          st, st_nxt;
  logic [HW-1:0]   halt_len, halt_len_nxt;
  logic [XLEN-1:0] pc_prev;
  logic            retire;
  logic            fifo_drop;
  logic [NCHK-1:0] lane_diff;

  assign retire = (st == ST_RUN) && wb_en && (wb_rd != REG_X0);
  assign state  = st;
  assign done   = (st == ST_DONE);
  assign pass   = (st == ST_DONE) && (mismatch_mask == '0) && !trace_overflow;

  always_comb begin
    lane_diff = '0;
    for (int i = 0; i < NCHK; i++)
      lane_diff[i] = (chk_act[i*XLEN +: XLEN] != chk_exp[i*XLEN +: XLEN]);
  end

  // halt_len is the number of consecutive RUN samples at the current PC,
  // counting the sample where it first appeared; zero outside RUN.
  always_comb begin
    st_nxt       = st;
    halt_len_nxt = '0;
    case (st)
      ST_IDLE: if (start) st_nxt = ST_RUN;
      ST_RUN: begin
        if (halt_len == '0 || pc_if != pc_prev) halt_len_nxt = HW'(1);
        else                                    halt_len_nxt = halt_len + HW'(1);
        if (cycle_count == CYC_LAST || halt_len_nxt >= HALT_LIM) st_nxt = ST_CHECK;
      end
      ST_CHECK: st_nxt = ST_DONE;
      ST_DONE:  st_nxt = ST_DONE;
      default:  st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st             <= ST_IDLE;
      halt_len       <= '0;
      pc_prev        <= '0;
      cycle_count    <= '0;
      retire_count   <= '0;
      trace_overflow <= 1'b0;
      mismatch_mask  <= '0;
    end else begin
      st       <= st_nxt;
      halt_len <= halt_len_nxt;
      pc_prev  <= pc_if;
      if (st == ST_IDLE && start) begin
        cycle_count  <= '0;
        retire_count <= '0;
      end else begin
        if (st == ST_RUN) cycle_count  <= sat_inc(cycle_count);
        if (retire)       retire_count <= sat_inc(retire_count);
      end
      if (fifo_drop)       trace_overflow <= 1'b1;
      if (st == ST_CHECK)  mismatch_mask  <= lane_diff;
    end
  end

  trace_fifo #(
    .WIDTH (5 + XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (retire),
    .wdata ({wb_rd, wb_data}),
    .ready (trace_ready),
    .valid (trace_valid),
    .rdata ({trace_rd, trace_data}),
    .count (trace_count),
    .drop  (fifo_drop)
  );

endmodule

// File: tb/tb_wb_trace_checker.sv
// Bench for wb_trace_checker: directed and random runs against a queue-based
// reference of the trace, halt/timeout end cycle and check verdict.
module tb_wb_trace_checker;
  localparam int XLEN  = 32;
  localparam int DEPTH = 16;
  localparam int NCHK  = 8;
  localparam int MAXC  = 40;
  localparam int HALT  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 wb_en = 1'b0;
  logic [4:0]           wb_rd = '0;
  logic [XLEN-1:0]      wb_data = '0;
  logic [XLEN-1:0]      pc_if = '0;
  logic [NCHK*XLEN-1:0] chk_act = '0;
  logic [NCHK*XLEN-1:0] chk_exp = '0;
  logic                 trace_ready = 1'b0;
  logic                 trace_valid;
  logic [4:0]           trace_rd;
  logic [XLEN-1:0]      trace_data;
  logic [$clog2(DEPTH):0] trace_count;
  logic                 trace_overflow;
  logic [31:0]          cycle_count;
  logic [31:0]          retire_count;
  logic [1:0]           state;
  logic                 done;
  logic                 pass;
  logic [NCHK-1:0]      mismatch_mask;

  wb_trace_checker #(
    .XLEN(XLEN), .DEPTH(DEPTH), .NCHK(NCHK), .MAX_CYCLES(MAXC), .HALT_CYCLES(HALT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .pc_if(pc_if), .chk_act(chk_act), .chk_exp(chk_exp),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_rd(trace_rd),
    .trace_data(trace_data), .trace_count(trace_count), .trace_overflow(trace_overflow),
    .cycle_count(cycle_count), .retire_count(retire_count), .state(state),
    .done(done), .pass(pass), .mismatch_mask(mismatch_mask)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

  logic [31:0] s_pc   [MAXC];
  bit          s_en   [MAXC];
  logic [4:0]  s_rd   [MAXC];
  logic [31:0] s_data [MAXC];
  bit          s_rdy  [MAXC];

  ent_t q[$];
  ent_t dut_popped[$];
  bit   m_ovf;
  int   m_ret;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; wb_en = 1'b0; trace_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic clear_stim();
    for (int k = 0; k < MAXC; k++) begin
      s_pc[k] = 32'h100 + 32'(4*k); s_en[k] = 1'b0; s_rd[k] = '0;
      s_data[k] = '0; s_rdy[k] = 1'b0;
    end
    chk_exp = '0; chk_act = '0;
  endtask

  // First RUN cycle whose last HALT PCs are identical, else the timeout cycle.
  function automatic int expected_end();
    for (int k = 0; k < MAXC; k++) begin
      if (k == MAXC - 1) return k;
      if (k >= HALT - 1) begin
        bit same = 1'b1;
        for (int j = k - HALT + 1; j < k; j++) if (s_pc[j] != s_pc[k]) same = 1'b0;
        if (same) return k;
      end
    end
    return MAXC - 1;
  endfunction

  task automatic run_case(input string name);
    int kend;
    logic [NCHK-1:0] exp_mask;
    bit exp_pass;
    int n;
    do_reset();
    exp_mask = '0;
    for (int i = 0; i < NCHK; i++)
      exp_mask[i] = (chk_act[i*XLEN +: XLEN] != chk_exp[i*XLEN +: XLEN]);
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (state !== 2'd1) begin errors++; $display("FAIL %s enter_run: state=%0d want 1", name, state); end
    kend = expected_end();
    q.delete(); dut_popped.delete(); m_ovf = 1'b0; m_ret = 0;
    for (int k = 0; k <= kend; k++) begin
      checks++;
      if (trace_count !== ($clog2(DEPTH)+1)'(q.size()) || trace_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL %s occupancy k=%0d: count=%0d valid=%0b want %0d", name, k, trace_count, trace_valid, q.size());
      end
      if (q.size() != 0) begin
        checks++;
        if (trace_rd !== q[0].rd || trace_data !== q[0].d) begin
          errors++;
          $display("FAIL %s head k=%0d: got (%0d,%h) want (%0d,%h)", name, k, trace_rd, trace_data, q[0].rd, q[0].d);
        end
      end
      checks++;
      if (cycle_count !== 32'(k)) begin errors++; $display("FAIL %s cycle_count k=%0d: got %0d", name, k, cycle_count); end
      wb_en = s_en[k]; wb_rd = s_rd[k]; wb_data = s_data[k]; pc_if = s_pc[k]; trace_ready = s_rdy[k];
      if (s_rdy[k] && q.size() != 0) begin
        ent_t e;
        e.rd = trace_rd; e.d = trace_data;
        dut_popped.push_back(e);
        void'(q.pop_front());
      end
      if (s_en[k] && s_rd[k] != 5'd0) begin
        ent_t e;
        e.rd = s_rd[k]; e.d = s_data[k];
        m_ret++;
        if (q.size() < DEPTH) q.push_back(e); else m_ovf = 1'b1;
      end
      tick();
      if (k < kend) begin
        checks++;
        if (state !== 2'd1) begin errors++; $display("FAIL %s early_exit k=%0d: state=%0d want 1", name, k, state); end
      end
    end
    wb_en = 1'b0; trace_ready = 1'b0;
    checks++;
    if (state !== 2'd2) begin errors++; $display("FAIL %s check_state: state=%0d want 2 (end k=%0d)", name, state, kend); end
    tick();
    exp_pass = (exp_mask == '0) && !m_ovf;
    checks++;
    if (state !== 2'd3 || done !== 1'b1 || pass !== exp_pass || mismatch_mask !== exp_mask) begin
      errors++;
      $display("FAIL %s verdict: state=%0d done=%0b pass=%0b mask=%h want 3 1 %0b %h", name, state, done, pass, mismatch_mask, exp_pass, exp_mask);
    end
    checks++;
    if (cycle_count !== 32'(kend + 1) || retire_count !== 32'(m_ret)) begin
      errors++;
      $display("FAIL %s counters: cycle=%0d retire=%0d want %0d %0d", name, cycle_count, retire_count, kend + 1, m_ret);
    end
    checks++;
    if (trace_overflow !== m_ovf || trace_count !== ($clog2(DEPTH)+1)'(q.size())) begin
      errors++;
      $display("FAIL %s fifo_end: ovf=%0b count=%0d want %0b %0d", name, trace_overflow, trace_count, m_ovf, q.size());
    end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if (state !== 2'd3) begin errors++; $display("FAIL %s start_in_done: state=%0d want 3", name, state); end
    trace_ready = 1'b1;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_rd !== q[0].rd || trace_data !== q[0].d) begin
        errors++;
        $display("FAIL %s drain %0d: v=%0b (%0d,%h) want (%0d,%h)", name, i, trace_valid, trace_rd, trace_data, q[0].rd, q[0].d);
      end
      void'(q.pop_front());
      tick();
    end
    trace_ready = 1'b0;
    checks++;
    if (trace_valid !== 1'b0 || trace_count !== '0) begin
      errors++; $display("FAIL %s drained: valid=%0b count=%0d want 0 0", name, trace_valid, trace_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 2'd0 || trace_valid !== 1'b0 || trace_count !== '0 || trace_overflow !== 1'b0 ||
        done !== 1'b0 || pass !== 1'b0 || mismatch_mask !== '0 || cycle_count !== '0 || retire_count !== '0) begin
      errors++;
      $display("FAIL reset: st=%0d v=%0b cnt=%0d ovf=%0b done=%0b pass=%0b mask=%h cyc=%0d ret=%0d want all 0",
               state, trace_valid, trace_count, trace_overflow, done, pass, mismatch_mask, cycle_count, retire_count);
    end
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'h77; tick(); tick(); wb_en = 1'b0;
    checks++;
    if (state !== 2'd0 || retire_count !== '0 || trace_count !== '0) begin
      errors++; $display("FAIL idle_wb: st=%0d ret=%0d cnt=%0d want 0 0 0", state, retire_count, trace_count);
    end
  endtask

  task automatic test_basic_trace();
    clear_stim();
    s_en[0] = 1; s_rd[0] = 5'd1; s_data[0] = 32'h5;
    s_en[1] = 1; s_rd[1] = 5'd2; s_data[1] = 32'hA;
    s_en[2] = 1; s_rd[2] = 5'd0; s_data[2] = 32'h7;
    for (int k = 0; k < MAXC; k++) s_rdy[k] = 1'b1;
    run_case("basic");
    checks++;
    if (dut_popped.size() != 2 || dut_popped[0].rd !== 5'd1 || dut_popped[0].d !== 32'h5 ||
        dut_popped[1].rd !== 5'd2 || dut_popped[1].d !== 32'hA) begin
      errors++; $display("FAIL basic_order: %0d entries seen, want (1,5) then (2,a)", dut_popped.size());
    end
    checks++;
    if (retire_count !== 32'd2) begin errors++; $display("FAIL basic_retire: got %0d want 2", retire_count); end
  endtask

  task automatic test_overflow();
    clear_stim();
    for (int k = 0; k < 17; k++) begin s_en[k] = 1; s_rd[k] = 5'(k % 31 + 1); s_data[k] = 32'hD00 + 32'(k); end
    run_case("overflow");
    checks++;
    if (trace_overflow !== 1'b1 || pass !== 1'b0 || retire_count !== 32'd17) begin
      errors++; $display("FAIL overflow_flags: ovf=%0b pass=%0b ret=%0d want 1 0 17", trace_overflow, pass, retire_count);
    end
  endtask

  task automatic test_halt();
    clear_stim();
    for (int k = 10; k < MAXC; k++) s_pc[k] = 32'h30;
    run_case("halt");
    checks++;
    if (cycle_count !== 32'd14) begin errors++; $display("FAIL halt_cycles: got %0d want 14", cycle_count); end
  endtask

  task automatic test_mismatch();
    clear_stim();
    for (int i = 0; i < NCHK; i++) begin
      chk_exp[i*XLEN +: XLEN] = 32'h1000 + 32'(i);
      chk_act[i*XLEN +: XLEN] = 32'h1000 + 32'(i);
    end
    chk_act[3*XLEN +: XLEN] = 32'hBAD;
    run_case("mismatch");
    checks++;
    if (mismatch_mask !== 8'h08 || pass !== 1'b0 || cycle_count !== 32'd40) begin
      errors++; $display("FAIL mismatch_lane3: mask=%h pass=%0b cyc=%0d want 08 0 40", mismatch_mask, pass, cycle_count);
    end
  endtask

  task automatic test_full_push_pop();
    clear_stim();
    for (int k = 0; k < 17; k++) begin s_en[k] = 1; s_rd[k] = 5'(k + 1); s_data[k] = 32'hF00 + 32'(k); end
    s_rdy[16] = 1'b1;
    run_case("full_push_pop");
    checks++;
    if (trace_overflow !== 1'b0 || pass !== 1'b1) begin
      errors++; $display("FAIL full_push_pop: ovf=%0b pass=%0b want 0 1", trace_overflow, pass);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      logic [31:0] pc;
      clear_stim();
      pc = $urandom;
      for (int k = 0; k < MAXC; k++) begin
        if ($urandom_range(0, 9) < 5) pc = $urandom;
        s_pc[k]   = pc;
        s_en[k]   = ($urandom_range(0, 9) < 7);
        s_rd[k]   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        s_data[k] = $urandom;
        s_rdy[k]  = ($urandom_range(0, 9) < (r % 2 == 0 ? 6 : 2));
      end
      for (int i = 0; i < NCHK; i++) begin
        chk_exp[i*XLEN +: XLEN] = $urandom;
        chk_act[i*XLEN +: XLEN] = chk_exp[i*XLEN +: XLEN] ^ (($urandom_range(0, 4) == 0) ? 32'h1 : 32'h0);
      end
      run_case($sformatf("random%0d", r));
    end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    start = 1'b1; tick(); start = 1'b0;
    trace_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wb_en = 1'b1; wb_rd = 5'(k + 1); wb_data = 32'(k); pc_if = 32'h200 + 32'(4*k);
      tick();
    end
    wb_en = 1'b0;
    checks++;
    if (trace_count !== 5 || state !== 2'd1) begin
      errors++; $display("FAIL mid_run_pre: count=%0d st=%0d want 5 1", trace_count, state);
    end
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || trace_valid !== 1'b0 || trace_count !== '0 || cycle_count !== '0 || retire_count !== '0) begin
      errors++;
      $display("FAIL mid_run_reset: st=%0d v=%0b cnt=%0d cyc=%0d ret=%0d want 0", state, trace_valid, trace_count, cycle_count, retire_count);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (trace_valid !== 1'b0 || state !== 2'd0 || done !== 1'b0) begin
      errors++; $display("FAIL post_reset: v=%0b st=%0d done=%0b want 0 0 0", trace_valid, state, done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_trace();
    test_overflow();
    test_halt();
    test_mismatch();
    test_full_push_pop();
    test_random();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
